// File: rtl/score_display_if.sv
`default_nettype none
// ============================================================================
// Module      : score_display_if
// Description : Game-side bundle for score_display. The master drives the
//               score and the game event pulses; the slave (the display
//               block) returns the segment drive and the high-score status.
//               Signals:
//                 score[15:0]      packed BCD score, [15:12] thousands
//                 game_tick        one-cycle end-of-frame pulse
//                 game_start       one-cycle new-game pulse
//                 game_over        one-cycle end-of-game pulse
//                 show_high        1 = show high score, 0 = show snapshot
//                 seg[6:0]         {g,f,e,d,c,b,a}, active-high
//                 digit_en[3:0]    one-hot digit enable, bit0 = units
//                 high_score[15:0] best BCD score since reset
//                 new_high         last game beat the high score
//                 bcd_err          sticky, a non-BCD nibble was shown
// Revision    : 1.0 - initial release
// ============================================================================
interface score_display_if;
    logic [15:0] score;
    logic        game_tick;
    logic        game_start;
    logic        game_over;
    logic        show_high;
    logic [6:0]  seg;
    logic [3:0]  digit_en;
    logic [15:0] high_score;
    logic        new_high;
    logic        bcd_err;

    modport master (
        output score, game_tick, game_start, game_over, show_high,
        input  seg, digit_en, high_score, new_high, bcd_err
    );

    modport slave (
        input  score, game_tick, game_start, game_over, show_high,
        output seg, digit_en, high_score, new_high, bcd_err
    );
endinterface
`default_nettype wire

// File: rtl/score_display.sv
`default_nettype none
// ============================================================================
// Module      : score_display
// Description : Four-digit multiplexed 7-segment score display with
//               per-frame snapshot, high-score tracking, leading-zero
//               blanking and a sticky non-BCD error flag.
//               Ports:
//                 clk   rising-edge clock
//                 rst   synchronous active-high reset
//                 bus   score_display_if.slave (score/events in,
//                       seg/digit_en/high_score/new_high/bcd_err out)
//               Parameters:
//                 SCAN_DIV       clk cycles per digit (2..65536)
//                 BLANK_LEADING  1 = blank leading-zero digits
// Revision    : 1.0 - initial release
// ============================================================================
module score_display #(
    parameter int SCAN_DIV      = 1024,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  wire logic      clk,
    input  wire logic      rst,
    score_display_if.slave bus
);

    localparam int                   c_PRESC_W   = $clog2(SCAN_DIV);
    localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(SCAN_DIV - 1);

    logic [15:0]          r_snap;
    logic [15:0]          r_high;
    logic                 r_new_high;
    logic                 r_bcd_err;
    logic [c_PRESC_W-1:0] r_presc;
    logic [1:0]           r_idx;
    logic [6:0]           r_seg;
    logic [3:0]           r_digit_en;

    logic [15:0] w_src;
    logic [3:0]  w_nib;
    logic        w_upper_zero;
    logic        w_blank;
    logic        w_bad;
    logic [6:0]  w_seg_code;
    logic [6:0]  w_seg_next;

    // Source is chosen combinationally every cycle, so a show_high or
    // snapshot change lands on the very next seg update mid-digit.
    assign w_src = bus.show_high ? r_high : r_snap;
    assign w_nib = w_src[{r_idx, 2'b00} +: 4];

    // A digit is a leading zero when it and every more-significant digit
    // are zero; the units digit is always shown.
    always_comb begin
        w_upper_zero = 1'b0;
        case (r_idx)
            2'd0:    w_upper_zero = 1'b0;
            2'd1:    w_upper_zero = (w_src[15:4]  == 12'h000);
            2'd2:    w_upper_zero = (w_src[15:8]  == 8'h00);
            default: w_upper_zero = (w_src[15:12] == 4'h0);
        endcase
    end

    assign w_blank = BLANK_LEADING && w_upper_zero;
    // A blanked digit is zero by construction, so it can never be non-BCD.
    assign w_bad   = (w_nib > 4'd9);

    always_comb begin
        w_seg_code = 7'h40;
        case (w_nib)
            4'd0:    w_seg_code = 7'h3F;
            4'd1:    w_seg_code = 7'h06;
            4'd2:    w_seg_code = 7'h5B;
            4'd3:    w_seg_code = 7'h4F;
            4'd4:    w_seg_code = 7'h66;
            4'd5:    w_seg_code = 7'h6D;
            4'd6:    w_seg_code = 7'h7D;
            4'd7:    w_seg_code = 7'h07;
            4'd8:    w_seg_code = 7'h7F;
            4'd9:    w_seg_code = 7'h6F;
            default: w_seg_code = 7'h40;
        endcase
    end

    assign w_seg_next = w_blank ? 7'h00 : w_seg_code;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap     <= 16'h0000;
            r_high     <= 16'h0000;
            r_new_high <= 1'b0;
            r_bcd_err  <= 1'b0;
            r_presc    <= '0;
            r_idx      <= 2'd0;
            r_seg      <= 7'h00;
            r_digit_en <= 4'b0000;
        end else begin
            if (bus.game_tick) begin
                r_snap <= bus.score;
            end

            // game_over takes priority: a coincident game_start never
            // clears the flag that this game may have just set.
            if (bus.game_over) begin
                if (bus.score > r_high) begin
                    r_high     <= bus.score;
                    r_new_high <= 1'b1;
                end
            end else if (bus.game_start) begin
                r_new_high <= 1'b0;
            end

            if (r_presc == c_PRESC_MAX) begin
                r_presc <= '0;
                r_idx   <= r_idx + 2'd1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end

            r_digit_en <= 4'b0001 << r_idx;
            r_seg      <= w_seg_next;
            r_bcd_err  <= r_bcd_err | w_bad;
        end
    end

    assign bus.seg        = r_seg;
    assign bus.digit_en   = r_digit_en;
    assign bus.high_score = r_high;
    assign bus.new_high   = r_new_high;
    assign bus.bcd_err    = r_bcd_err;

endmodule
`default_nettype wire
